// File: rtl/dmx_pkg.sv
// DMX512 shared definitions: detector FSM states and the us-to-cycles
// conversion used by the frame detector and the slot UART.
package dmx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_MAB       = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } dmx_state_e;

    // Whole cycles per microsecond times the duration. The 64-bit math keeps
    // long windows (1 s at tens of MHz) from overflowing.
    function automatic longint unsigned us_to_cycles(input longint unsigned clk_freq,
                                                     input longint unsigned us);
        return (clk_freq / 64'd1_000_000) * us;
    endfunction

endpackage

// File: rtl/dmx_line_filter.sv
// RX line conditioner: 2-FF synchroniser followed by a glitch filter.
// filt_o takes a new level only after FILT_LEN consecutive synchronised
// samples disagree with it. fall_o/rise_o are single-cycle edge strobes
// of filt_o.
//   clk, rst_n : clock, async active-low reset
//   rx_i       : raw asynchronous line (idles high)
//   filt_o     : filtered level
//   fall_o     : filtered high->low edge strobe
//   rise_o     : filtered low->high edge strobe
module dmx_line_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic filt_o,
    output logic fall_o,
    output logic rise_o
);

    logic       s1_q, s2_q;
    logic       filt_q, filt_dly_q;
    logic [3:0] fcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
            fcnt_q     <= '0;
        end else begin
            s1_q       <= rx_i;
            s2_q       <= s1_q;
            filt_dly_q <= filt_q;
            // Any agreeing sample restarts the run of disagreeing samples.
            if (s2_q != filt_q) begin
                if (fcnt_q == 4'(FILT_LEN - 1)) begin
                    filt_q <= s2_q;
                    fcnt_q <= '0;
                end else begin
                    fcnt_q <= fcnt_q + 4'd1;
                end
            end else begin
                fcnt_q <= '0;
            end
        end
    end

    assign filt_o = filt_q;
    assign fall_o = filt_dly_q & ~filt_q;
    assign rise_o = ~filt_dly_q & filt_q;

endmodule

// File: rtl/dmx_break_mab_detector.sv
// DMX512 frame-start detector. Measures the filtered BREAK low and the
// following MAB high, checks both against min/max windows, and pulses
// frame_start on the falling edge of the slot-0 start bit.
//   clk, rst_n     : clock, async active-low reset
//   rx_in          : raw DMX line (idles high)
//   enable         : synchronous enable; low forces IDLE
//   break_ok       : pulse, valid BREAK ended
//   frame_start    : pulse, start bit after a valid MAB
//   break_len      : last valid BREAK length (cycles)
//   mab_len        : last valid MAB length (cycles)
//   err_long_break : pulse, low exceeded the BREAK maximum
//   err_mab        : pulse, MAB too short or too long
//   busy           : FSM not in IDLE
module dmx_break_mab_detector
    import dmx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 20_000_000,
    parameter int unsigned BRK_MIN_US = 88,
    parameter int unsigned BRK_MAX_US = 1_000_000,
    parameter int unsigned MAB_MIN_US = 8,
    parameter int unsigned MAB_MAX_US = 1_000_000,
    parameter int unsigned FILT_LEN   = 3,
    parameter int unsigned CNT_W      = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_in,
    input  logic             enable,
    output logic             break_ok,
    output logic             frame_start,
    output logic [CNT_W-1:0] break_len,
    output logic [CNT_W-1:0] mab_len,
    output logic             err_long_break,
    output logic             err_mab,
    output logic             busy
);

    localparam logic [CNT_W-1:0] BRK_MIN_CYC = CNT_W'(us_to_cycles(CLK_FREQ, BRK_MIN_US));
    localparam logic [CNT_W-1:0] BRK_MAX_CYC = CNT_W'(us_to_cycles(CLK_FREQ, BRK_MAX_US));
    localparam logic [CNT_W-1:0] MAB_MIN_CYC = CNT_W'(us_to_cycles(CLK_FREQ, MAB_MIN_US));
    localparam logic [CNT_W-1:0] MAB_MAX_CYC = CNT_W'(us_to_cycles(CLK_FREQ, MAB_MAX_US));

    logic filt, fall, rise;

    dmx_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_i   (rx_in),
        .filt_o (filt),
        .fall_o (fall),
        .rise_o (rise)
    );

    dmx_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             break_ok_q, frame_start_q, err_long_q, err_mab_q;
    logic [CNT_W-1:0] break_len_q, mab_len_q;

    // Saturating increment; the limit checks normally stop cnt well before.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            break_ok_q    <= 1'b0;
            frame_start_q <= 1'b0;
            err_long_q    <= 1'b0;
            err_mab_q     <= 1'b0;
            break_len_q   <= '0;
            mab_len_q     <= '0;
        end else begin
            break_ok_q    <= 1'b0;
            frame_start_q <= 1'b0;
            err_long_q    <= 1'b0;
            err_mab_q     <= 1'b0;
            if (!enable) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (fall) begin
                            state_q <= ST_BREAK;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    // Edges win over the limit check and use the
                    // pre-increment count, so a BREAK of exactly the
                    // maximum still qualifies.
                    ST_BREAK: begin
                        if (rise) begin
                            if (cnt_q >= BRK_MIN_CYC) begin
                                break_ok_q  <= 1'b1;
                                break_len_q <= cnt_q;
                                state_q     <= ST_MAB;
                                cnt_q       <= CNT_W'(1);
                            end else begin
                                // Ordinary data-bit low: not an error.
                                state_q <= ST_IDLE;
                                cnt_q   <= '0;
                            end
                        end else if (cnt_q == BRK_MAX_CYC) begin
                            err_long_q <= 1'b1;
                            state_q    <= ST_WAIT_HIGH;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= sat_inc(cnt_q);
                        end
                    end
                    ST_MAB: begin
                        if (fall) begin
                            if (cnt_q >= MAB_MIN_CYC) begin
                                frame_start_q <= 1'b1;
                                mab_len_q     <= cnt_q;
                                state_q       <= ST_IDLE;
                                cnt_q         <= '0;
                            end else begin
                                // Short MAB: this fall opens a fresh BREAK.
                                err_mab_q <= 1'b1;
                                state_q   <= ST_BREAK;
                                cnt_q     <= CNT_W'(1);
                            end
                        end else if (cnt_q == MAB_MAX_CYC) begin
                            err_mab_q <= 1'b1;
                            state_q   <= ST_IDLE;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= sat_inc(cnt_q);
                        end
                    end
                    ST_WAIT_HIGH: begin
                        if (rise) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign break_ok       = break_ok_q;
    assign frame_start    = frame_start_q;
    assign err_long_break = err_long_q;
    assign err_mab        = err_mab_q;
    assign break_len      = break_len_q;
    assign mab_len        = mab_len_q;
    assign busy           = (state_q != ST_IDLE);

    // The filtered level itself is only consumed through its edge strobes.
    logic unused_filt;
    assign unused_filt = filt;

endmodule

// File: tb/tb_dmx_break_mab_detector.sv
// Bench for dmx_break_mab_detector. The line is described as a list of
// logical segments (level, duration); the reference model walks the list and
// derives the expected pulses and their cycle stamps from the window rules.
// Sub-FILT_LEN glitches and one-cycle enable drops are layered on at drive time.
module tb_dmx_break_mab_detector;

    localparam int unsigned CLK_FREQ   = 1_000_000;
    localparam int unsigned BRK_MIN_US = 88;
    localparam int unsigned BRK_MAX_US = 400;
    localparam int unsigned MAB_MIN_US = 8;
    localparam int unsigned MAB_MAX_US = 300;
    localparam int unsigned FILT_LEN   = 3;
    localparam int unsigned CNT_W      = 12;
    localparam int BRK_MIN = 88, BRK_MAX = 400, MAB_MIN = 8, MAB_MAX = 300;
    localparam int LAT  = 3 + FILT_LEN;  // rx drive to registered pulse
    localparam int TAIL = MAB_MAX + 20;

    logic clk = 1'b0, rst_n = 1'b0, rx_in = 1'b1, enable = 1'b1;
    logic break_ok, frame_start, err_long_break, err_mab, busy;
    logic [CNT_W-1:0] break_len, mab_len;

    dmx_break_mab_detector #(
        .CLK_FREQ(CLK_FREQ), .BRK_MIN_US(BRK_MIN_US), .BRK_MAX_US(BRK_MAX_US),
        .MAB_MIN_US(MAB_MIN_US), .MAB_MAX_US(MAB_MAX_US),
        .FILT_LEN(FILT_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .enable(enable),
        .break_ok(break_ok), .frame_start(frame_start),
        .break_len(break_len), .mab_len(mab_len),
        .err_long_break(err_long_break), .err_mab(err_mab), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // kind: 0 break_ok, 1 frame_start, 2 err_long_break, 3 err_mab
    typedef struct {
        int          kind;
        int unsigned t;
        int unsigned len;
    } ev_t;
    ev_t exp_q[$], obs_q[$];
    int  both_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (break_ok)       obs_q.push_back('{kind: 0, t: cyc, len: break_len});
            if (frame_start)    obs_q.push_back('{kind: 1, t: cyc, len: mab_len});
            if (err_long_break) obs_q.push_back('{kind: 2, t: cyc, len: break_len});
            if (err_mab)        obs_q.push_back('{kind: 3, t: cyc, len: mab_len});
            if (break_ok && frame_start) both_cnt++;
        end
    end

    int seg_lvl[$], seg_dur[$];
    bit seg_gl[$], seg_ab[$];
    int last_brk = 0, last_mab = 0;

    task automatic add(input int lvl, input int dur, input bit gl = 0, input bit ab = 0);
        seg_lvl.push_back(lvl);
        seg_dur.push_back(dur);
        seg_gl.push_back(gl && dur >= 15);
        seg_ab.push_back(ab && !gl);
    endtask

    // Reference: every low that does not follow a valid MAB is a BREAK
    // candidate; every high that follows a valid BREAK is a MAB candidate.
    task automatic model(input int unsigned s0);
        int unsigned s = s0;
        bit is_break = 1, cand = 0;
        for (int i = 0; i < seg_lvl.size(); i++) begin
            int d = seg_dur[i];
            if (seg_lvl[i] == 0) begin
                cand = 0;
                if (is_break) begin
                    if (d > BRK_MAX)
                        exp_q.push_back('{kind: 2, t: s + LAT + BRK_MAX, len: last_brk});
                    else if (d >= BRK_MIN) begin
                        last_brk = d;
                        exp_q.push_back('{kind: 0, t: s + d + LAT, len: d});
                        cand = 1;
                    end
                end
                is_break = 1;
            end else begin
                if (!cand || d < 20) seg_ab[i] = 0;
                if (cand && !seg_ab[i]) begin
                    if (d > MAB_MAX) begin
                        exp_q.push_back('{kind: 3, t: s + LAT + MAB_MAX, len: last_mab});
                        is_break = 1;
                    end else if (d >= MAB_MIN) begin
                        last_mab = d;
                        exp_q.push_back('{kind: 1, t: s + d + LAT, len: d});
                        is_break = 0;
                    end else begin
                        exp_q.push_back('{kind: 3, t: s + d + LAT, len: last_mab});
                        is_break = 1;
                    end
                end else begin
                    is_break = 1;
                end
                cand = 0;
            end
            s += d;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a posedge; drives the list, then compares event logs.
    task automatic run(input string name);
        add(1, TAIL);
        model(cyc);
        for (int i = 0; i < seg_lvl.size(); i++) begin
            rx_in = seg_lvl[i][0];
            if (seg_gl[i]) begin
                int a = seg_dur[i] / 3;
                int g = 1 + int'($urandom_range(FILT_LEN - 2));
                wait_cyc(a);
                rx_in = ~seg_lvl[i][0];
                wait_cyc(g);
                rx_in = seg_lvl[i][0];
                wait_cyc(seg_dur[i] - a - g);
            end else if (seg_ab[i]) begin
                wait_cyc(seg_dur[i] / 2);
                enable = 1'b0;
                wait_cyc(1);
                enable = 1'b1;
                wait_cyc(seg_dur[i] - seg_dur[i] / 2 - 1);
            end else begin
                wait_cyc(seg_dur[i]);
            end
        end
        wait_cyc(LAT + 4);
        chk({name, ".n_events"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s.ev%0d.kind", name, i), obs_q[i].kind, exp_q[i].kind);
            chk($sformatf("%s.ev%0d.cycle", name, i), obs_q[i].t, exp_q[i].t);
            chk($sformatf("%s.ev%0d.len", name, i), obs_q[i].len, exp_q[i].len);
        end
        chk({name, ".busy_idle"}, busy, 0);
        exp_q.delete(); obs_q.delete();
        seg_lvl.delete(); seg_dur.delete(); seg_gl.delete(); seg_ab.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".break_ok"}, break_ok, 0);
        chk({name, ".frame_start"}, frame_start, 0);
        chk({name, ".err_long"}, err_long_break, 0);
        chk({name, ".err_mab"}, err_mab, 0);
        chk({name, ".break_len"}, break_len, 0);
        chk({name, ".mab_len"}, mab_len, 0);
        chk({name, ".busy"}, busy, 0);
    endtask

    function automatic int rnd_low();
        case ($urandom_range(4))
            0: return int'($urandom_range(87, 4));
            1: return int'($urandom_range(90, 86));
            2: return int'($urandom_range(399, 88));
            3: return int'($urandom_range(402, 398));
            default: return int'($urandom_range(440, 401));
        endcase
    endfunction

    function automatic int rnd_high();
        case ($urandom_range(4))
            0: return int'($urandom_range(7, 4));
            1: return int'($urandom_range(9, 7));
            2: return int'($urandom_range(299, 8));
            3: return int'($urandom_range(302, 299));
            default: return int'($urandom_range(330, 301));
        endcase
    endfunction

    initial begin
        #1;
        chk_all_zero("reset");
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(20);

        // valid BREAK / MAB / start bit
        add(0, 120); add(1, 12); add(0, 20);
        run("basic");
        // BREAK one cycle short, then exactly the minimum
        add(0, BRK_MIN - 1); add(1, 50); add(0, BRK_MIN); add(1, 10); add(0, 10);
        run("brk_min");
        // overlong low, then exact BREAK max and exact MAB max
        add(0, BRK_MAX + 1); add(1, 30); add(0, BRK_MAX); add(1, MAB_MAX); add(0, 10);
        run("brk_max");
        // short MAB re-arms BREAK, then exact MAB min
        add(0, 120); add(1, MAB_MIN - 3); add(0, 100); add(1, MAB_MIN); add(0, 10);
        run("short_mab");
        // glitches on idle high and inside a BREAK
        add(1, 40, 1); add(0, 120, 1); add(1, 20, 1); add(0, 10);
        run("glitch");
        // enable dropped mid-MAB
        add(0, 120); add(1, 40, 0, 1); add(0, 100); add(1, 10); add(0, 10);
        run("enable");

        for (int it = 0; it < 30; it++) begin
            int np = 1 + int'($urandom_range(1));
            for (int p = 0; p < np; p++) begin
                add(0, rnd_low(), $urandom_range(3) == 0);
                add(1, rnd_high(), $urandom_range(3) == 0, $urandom_range(4) == 0);
            end
            add(0, int'($urandom_range(20, 4)));
            run($sformatf("rnd%0d", it));
        end

        // reset in the middle of a BREAK
        rx_in = 1'b0;
        wait_cyc(60);
        chk("midbrk.busy_before", busy, 1);
        #2 rst_n = 1'b0;
        rx_in = 1'b1;
        #1;
        chk_all_zero("midbrk_reset");
        wait_cyc(3);
        rst_n = 1'b1;
        last_brk = 0; last_mab = 0;
        obs_q.delete();
        wait_cyc(20);
        add(0, 150); add(1, 25); add(0, 10);
        run("after_reset");

        chk("brk_and_frame_together", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
